axe_ccl_rst_seq: RTL and testbench

AXE_CCL_RST_SEQ -- requirements
Module: axe_ccl_rst_seq

---
 rtl/axe_ccl_rst_seq_pkg.sv | 15 +
 rtl/axe_ccl_rst_seq.sv | 145 ++++++++++++++
 tb/tb_axe_ccl_rst_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axe_ccl_rst_seq_pkg.sv
// Shared state encoding and default sizing for the staged reset sequencer.
package axe_ccl_rst_seq_pkg;

  localparam int NUM_DOMAINS_DEF = 4;
  localparam int DELAY_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_CAPT,
    ST_RELEASE,
    ST_RUN,
    ST_ASSERT,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/axe_ccl_rst_seq.sv
// Staged reset sequencer: releases domains 0..N-1, re-asserts N-1..0 on a software request.
// Optional macro AXE_RST_SEQ_DOM_ACK_EN adds per-domain release handshakes (i_dom_ack).
module axe_ccl_rst_seq
  import axe_ccl_rst_seq_pkg::*;
#(
  parameter int NumDomains = NUM_DOMAINS_DEF,
  parameter int DelayWidth = DELAY_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_test_mode,
  input  logic                  i_test_rst_n,
  input  logic [DelayWidth-1:0] i_delay,
  input  logic                  i_sw_rst_req,
`ifdef AXE_RST_SEQ_DOM_ACK_EN
  input  logic [NumDomains-1:0] i_dom_ack,
`endif
  output logic                  o_sw_rst_ack,
  output logic [NumDomains-1:0] o_rst_n,
  output logic                  o_busy
);

  // One spare code so the handshake build can park idx at NumDomains while waiting.
  localparam int                IdxW    = $clog2(NumDomains + 1);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NumDomains - 1);

  state_e                  state_q, state_d;
  logic [DelayWidth-1:0]   cnt_q, cnt_d;
  logic [DelayWidth-1:0]   dly_q, dly_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NumDomains-1:0]   rst_q, rst_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    step_en;

`ifdef AXE_RST_SEQ_DOM_ACK_EN
  always_comb begin
    step_en = 1'b1;
    for (int k = 0; k < NumDomains; k++) begin
      if (idx_q == IdxW'(k + 1) && !i_dom_ack[k]) step_en = 1'b0;
    end
  end
`else
  assign step_en = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_CAPT: begin
        dly_d   = i_delay;
        cnt_d   = i_delay;
        idx_d   = '0;
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (idx_q == IdxW'(NumDomains)) begin
          if (step_en) state_d = ST_RUN;
        end else if (step_en) begin
          if (cnt_q == '0) begin
            for (int k = 0; k < NumDomains; k++) begin
              if (idx_q == IdxW'(k)) rst_d[k] = 1'b1;
            end
            cnt_d = dly_q;
            idx_d = idx_q + 1'b1;
`ifndef AXE_RST_SEQ_DOM_ACK_EN
            if (idx_q == LastIdx) state_d = ST_RUN;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (i_sw_rst_req) begin
          idx_d   = LastIdx;
          cnt_d   = dly_q;
          state_d = ST_ASSERT;
        end
      end

      ST_ASSERT: begin
        if (cnt_q == '0) begin
          for (int k = 0; k < NumDomains; k++) begin
            if (idx_q == IdxW'(k)) rst_d[k] = 1'b0;
          end
          cnt_d = dly_q;
          if (idx_q == '0) state_d = ST_HOLD;
          else             idx_d   = idx_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_CAPT;
    endcase

    busy_d = (state_d != ST_RUN);
  end

  // NOTE: reset is sampled on the clock edge; state updates use non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CAPT;
      cnt_q   <= '0;
      dly_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Test bypass overrides the outputs only; the sequencer keeps running underneath.
  assign o_rst_n      = i_test_mode ? {NumDomains{i_test_rst_n}} : rst_q;
  assign o_busy       = busy_q;
  assign o_sw_rst_ack = ack_q;

endmodule

// File: tb/tb_axe_ccl_rst_seq.sv
// Self-checking bench for axe_ccl_rst_seq: directed tables, corner sequences and a random run
// compared every cycle against a release/assert schedule computed from step arithmetic.
module tb_axe_ccl_rst_seq;
  import axe_ccl_rst_seq_pkg::*;

  localparam int N  = NUM_DOMAINS_DEF;
  localparam int DW = DELAY_WIDTH_DEF;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          test_mode  = 1'b0;
  logic          test_rst_n = 1'b0;
  logic [DW-1:0] delay      = '0;
  logic          sw_req     = 1'b0;
  logic          ack;
  logic [N-1:0]  rst_out;
  logic          busy;
`ifdef AXE_RST_SEQ_DOM_ACK_EN
  logic [N-1:0]  dom_ack    = '1;
`endif

  always #5 clk = ~clk;

  axe_ccl_rst_seq #(.NumDomains(N), .DelayWidth(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_test_mode  (test_mode),
    .i_test_rst_n (test_rst_n),
    .i_delay      (delay),
    .i_sw_rst_req (sw_req),
`ifdef AXE_RST_SEQ_DOM_ACK_EN
    .i_dom_ack    (dom_ack),
`endif
    .o_sw_rst_ack (ack),
    .o_rst_n      (rst_out),
    .o_busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference schedule: a release started at edge m_rel frees one domain every D+1 edges;
  // a request taken at edge m_req clears one domain every D+1 edges, then holds D+1, then acks.
  int           t      = 0;
  int           m_capt = 0;
  int           m_rel  = 0;
  int           m_req  = -1;
  int           m_d    = 0;
  bit           m_valid = 0;
  logic [N-1:0] m_rst  = '0;
  logic         m_busy = 1'b1;
  logic         m_ack  = 1'b0;

  task automatic model_edge();
    int step;
    int n;
    if (!rst_n) begin
      m_capt  = t + 1;
      m_req   = -1;
      m_valid = 0;
      m_rst   = '0;
      m_busy  = 1'b1;
      m_ack   = 1'b0;
      return;
    end
    if (t == m_capt) begin
      m_d     = int'(delay);
      m_rel   = t;
      m_req   = -1;
      m_valid = 1;
    end else if (m_valid && m_req < 0 && t > m_rel + N * (m_d + 1) && sw_req) begin
      m_req  = t;
      m_capt = t + (N + 1) * (m_d + 1) + 1;
    end
    if (!m_valid) return;
    step = m_d + 1;
    if (m_req < 0) begin
      n      = (t - m_rel) / step;
      if (n > N) n = N;
      m_rst  = N'((1 << n) - 1);
      m_busy = (t < m_rel + N * step);
      m_ack  = 1'b0;
    end else begin
      n      = (t - m_req) / step;
      if (n > N) n = N;
      m_rst  = N'((1 << (N - n)) - 1);
      m_busy = 1'b1;
      m_ack  = (t == m_capt - 1);
    end
  endtask

  task automatic tick(input string name);
    logic [N-1:0] exp_rst;
    @(posedge clk);
    t++;
    model_edge();
    @(negedge clk);
    exp_rst = test_mode ? {N{test_rst_n}} : m_rst;
    check(name, 32'({ack, busy, rst_out}), 32'({m_ack, m_busy, exp_rst}));
  endtask

  task automatic pulse_req();
    sw_req = 1'b1;
    tick("req_pulse");
    sw_req = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick("wait_run");
      i++;
    end
    check("run_reached", 32'(busy), 32'(0));
  endtask

  typedef struct { int at; logic [3:0] rst; logic busy; } pon_vec_t;
  typedef struct { logic [3:0] rst; logic busy; logic ack; } sw_vec_t;
  typedef struct { logic tmode; logic trst; logic [3:0] rst; } byp_vec_t;

  initial begin
    pon_vec_t pon_tbl[9];
    sw_vec_t  sw_tbl[11];
    byp_vec_t byp_tbl[6];
    int       rise_at[N];
    int       rel;
    bit       ack_seen;
    logic [N-1:0] prev;

    pon_tbl[0] = '{0,  4'b0000, 1'b1};
    pon_tbl[1] = '{3,  4'b0000, 1'b1};
    pon_tbl[2] = '{4,  4'b0001, 1'b1};
    pon_tbl[3] = '{7,  4'b0001, 1'b1};
    pon_tbl[4] = '{8,  4'b0011, 1'b1};
    pon_tbl[5] = '{11, 4'b0011, 1'b1};
    pon_tbl[6] = '{12, 4'b0111, 1'b1};
    pon_tbl[7] = '{15, 4'b0111, 1'b1};
    pon_tbl[8] = '{16, 4'b1111, 1'b0};

    sw_tbl[0]  = '{4'b1111, 1'b1, 1'b0};
    sw_tbl[1]  = '{4'b0111, 1'b1, 1'b0};
    sw_tbl[2]  = '{4'b0011, 1'b1, 1'b0};
    sw_tbl[3]  = '{4'b0001, 1'b1, 1'b0};
    sw_tbl[4]  = '{4'b0000, 1'b1, 1'b0};
    sw_tbl[5]  = '{4'b0000, 1'b1, 1'b1};
    sw_tbl[6]  = '{4'b0000, 1'b1, 1'b0};
    sw_tbl[7]  = '{4'b0001, 1'b1, 1'b0};
    sw_tbl[8]  = '{4'b0011, 1'b1, 1'b0};
    sw_tbl[9]  = '{4'b0111, 1'b1, 1'b0};
    sw_tbl[10] = '{4'b1111, 1'b0, 1'b0};

    byp_tbl[0] = '{1'b1, 1'b0, 4'b0000};
    byp_tbl[1] = '{1'b1, 1'b1, 4'b1111};
    byp_tbl[2] = '{1'b1, 1'b1, 4'b1111};
    byp_tbl[3] = '{1'b1, 1'b0, 4'b0000};
    byp_tbl[4] = '{1'b1, 1'b1, 4'b1111};
    byp_tbl[5] = '{1'b1, 1'b0, 4'b0000};

    // Reset state
    rst_n = 1'b0;
    delay = 8'd3;
    repeat (3) tick("reset");
    check("reset_state", 32'({ack, busy, rst_out}), 32'({1'b0, 1'b1, 4'b0000}));

    // Power-on release with D=3; a later i_delay change must be ignored
    rst_n = 1'b1;
    rel   = -1;
    for (int i = 0; i < 9; i++) begin
      while (rel < pon_tbl[i].at) begin
        tick("pon_seq");
        rel++;
        if (rel == 1) delay = 8'd9;
      end
      check("pon_rst_n", 32'(rst_out), 32'(pon_tbl[i].rst));
      check("pon_busy",  32'(busy),    32'(pon_tbl[i].busy));
    end

    // Recapture D=0, then the single-pulse software reset cycle
    delay = 8'd0;
    pulse_req();
    wait_run(200);
    sw_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick("sw_seq");
      if (i == 0) sw_req = 1'b0;
      check("sw_cycle", 32'({rst_out, busy, ack}),
            32'({sw_tbl[i].rst, sw_tbl[i].busy, sw_tbl[i].ack}));
    end

    // Reset during ASSERT with o_rst_n=0011 aborts with no ack
    delay = 8'd2;
    pulse_req();
    wait_run(200);
    pulse_req();
    for (int i = 0; i < 100 && rst_out !== 4'b0011; i++) tick("to_0011");
    check("reach_0011", 32'(rst_out), 32'(4'b0011));
    rst_n = 1'b0;
    tick("abort");
    check("abort_state", 32'({busy, rst_out}), 32'({1'b1, 4'b0000}));
    rst_n    = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick("post_abort");
      if (ack) ack_seen = 1;
    end
    check("no_ack_after_abort", 32'(ack_seen), 32'(0));

    // Request held high: a new cycle starts right after RUN is re-entered
    sw_req = 1'b1;
    tick("held_req");
    wait_run(200);
    tick("held_restart");
    check("req_held_restart", 32'(busy), 32'(1));
    sw_req = 1'b0;
    wait_run(200);

    // Test bypass while the sequencer is asserting
    pulse_req();
    for (int i = 0; i < 6; i++) begin
      test_mode  = byp_tbl[i].tmode;
      test_rst_n = byp_tbl[i].trst;
      #1;
      check("bypass", 32'(rst_out), 32'(byp_tbl[i].rst));
      tick("bypass_seq");
    end
    test_mode = 1'b0;
    wait_run(200);

    // Maximum delay: 256 cycles between consecutive releases
    delay = 8'd255;
    pulse_req();
    for (int k = 0; k < N; k++) rise_at[k] = -1;
    prev = rst_out;
    for (int i = 0; i < 4000 && busy; i++) begin
      tick("max_delay");
      for (int k = 0; k < N; k++) begin
        if (!prev[k] && rst_out[k]) rise_at[k] = t;
      end
      prev = rst_out;
    end
    check("max_delay_run", 32'(busy), 32'(0));
    for (int k = 0; k < N - 1; k++) begin
      check("max_delay_gap", 32'(rise_at[k + 1] - rise_at[k]), 32'(256));
    end

    // Random stimulus against the schedule model
    for (int i = 0; i < 1500; i++) begin
      delay      = DW'($urandom_range(0, 4));
      sw_req     = ($urandom_range(0, 7) == 0);
      rst_n      = ($urandom_range(0, 149) != 0);
      test_mode  = ($urandom_range(0, 19) == 0);
      test_rst_n = 1'($urandom_range(0, 1));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
